ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- It is the opposite direction of the existing PS/2 keyboard receive path, and shares the ps2_clk/ps2_data lines through open-drain drive enables.
- Sits beside the receiver under top. Board logic pulses tx_start; the receiver must ignore the bus while tx_busy=1.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles ps2_clk is held low before start (120 us at 100 MHz, spec minimum 100 us).
- TIMEOUT_CYCLES, 200000, max clk cycles between consecutive expected device events (2 ms).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send; sampled only on an accepted tx_start
- tx_start  in  1  one-cycle request; accepted only in IDLE
- ps2_clk_in  in  1  raw PS/2 clock pin level
- ps2_data_in  in  1  raw PS/2 data pin level
- ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release (pulled up)
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release
- tx_busy  out  1  high from the accepting cycle until return to IDLE
- tx_done  out  1  one-cycle pulse: frame acknowledged, bus idle
- tx_err  out  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, state=IDLE, all counters 0. Reset mid-frame releases both lines on the reset edge; no done or error pulse.
- Input conditioning:
  - 2-FF synchronizer on both pins, plus a third register on the clock for edge detection.
  - fall = sync_clk_prev & ~sync_clk; asserted 3 clk cycles after the pin edge.
- Frame: shift register = {stop=1, parity, tx_data[7:0]}, LSB first. Parity is odd: parity = ~^tx_data.
- States:
  - IDLE: outputs released. On tx_start: latch frame, zero counters, tx_busy=1 next cycle, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0. Count INHIBIT_CYCLES, then set data_oe=1 (start bit) and go to REQ.
  - REQ: clk_oe=1, data_oe=1 for exactly 1 cycle, then clk_oe=0, go to SEND.
  - SEND: bit_cnt 0..9.
    - On each fall: data_oe <= ~frame[bit_cnt], bit_cnt++.
    - Fall #10 drives the stop bit (released), then go to ACK.
    - Data is changed only at falls; the device samples on rising edges.
  - ACK: on the next fall, sample sync_data. 0 → WAIT_IDLE; 1 → ERR.
  - WAIT_IDLE: wait until sync_clk=1 and sync_data=1 for 1 cycle, then DONE.
  - DONE: tx_done=1 for one cycle, tx_busy=0 next cycle, go to IDLE.
  - ERR: release both lines, tx_err=1 for one cycle, go to IDLE.
- Timeout:
  - Watchdog counts in REQ, SEND, ACK and WAIT_IDLE; cleared on every fall and on each state entry.
  - Reaching TIMEOUT_CYCLES → ERR.
  - The watchdog is inactive in IDLE and INHIBIT.
- tx_start while tx_busy=1 is ignored; tx_data changes during a frame have no effect.
- Falls seen in IDLE or INHIBIT are ignored, including the self-generated low.
- tx_done and tx_err never assert in the same cycle.
- Total latency from tx_start to first clk release = 1 + INHIBIT_CYCLES + 1 cycles.
- Counter widths: INHIBIT and watchdog counters 18 bits; bit_cnt 4 bits.

Test Plan:
- Inhibit timing: tx_start with tx_data=0xED → clk_oe high for exactly 12000 cycles, then data_oe=1 with clk_oe still 1 for 1 cycle, then clk_oe=0.
- Full frame to a device model (clock period 80 us, ACK driven low at the 11th fall) with tx_data=0xED:
  - Bits observed on rising edges: start 0, 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - Then one tx_done pulse; tx_busy drops the next cycle.
- Parity: 0xF4 → parity 0; 0x00 → parity 1; 0xFF → parity 1. All receive ACK and tx_done.
- No ACK: device model leaves data high at the 11th fall → tx_err pulse, both oe=0, tx_done never asserted.
- Silent device: no clocks after release → tx_err exactly TIMEOUT_CYCLES after entering REQ; a second tx_start pulse during the frame is ignored.
- Reset mid-frame: assert rst after fall #4 → both oe=0 and tx_busy=0 asynchronously. A following tx_start=0xF4 transmits a correct fresh frame.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device command transmitter driving open-drain enables
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [17:0] c_inhibit_last = 18'(INHIBIT_CYCLES - 1);
  localparam logic [17:0] c_timeout_last = 18'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INHIBIT   = 4'd1,
    S_REQ       = 4'd2,
    S_SEND      = 4'd3,
    S_ACK       = 4'd4,
    S_WAIT_IDLE = 4'd5,
    S_DONE      = 4'd6,
    S_ERR       = 4'd7
  } state_t;

  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s2_q, clk_s3_q;
  logic        data_s1_q, data_s2_q;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [17:0] inh_cnt_q, inh_cnt_d;
  logic [17:0] wd_q, wd_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        fall;
  logic        timeout;

  // Synchronisers idle high so a reset never looks like a clock fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_in;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      data_s1_q <= ps2_data_in;
      data_s2_q <= data_s1_q;
    end
  end

  assign fall    = clk_s3_q & ~clk_s2_q;
  assign timeout = (wd_q == c_timeout_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      wd_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      wd_q      <= wd_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Outputs are registered: each branch sets the value for the state being entered.
  // The watchdog runs on from REQ into SEND so the wait for the first device
  // clock is measured from the moment REQ is entered.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    wd_d      = wd_q + 18'd1;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        wd_d      = '0;
        if (tx_start) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        wd_d = '0;
        if (inh_cnt_q == c_inhibit_last) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 18'd1;
        end
      end
      S_REQ: begin
        clk_oe_d = 1'b0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          wd_d      = '0;
          data_oe_d = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_ACK: begin
        if (fall) begin
          wd_d    = '0;
          state_d = data_s2_q ? S_ERR : S_WAIT_IDLE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        wd_d    = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        wd_d    = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every path into ERR releases the bus and raises the error pulse.
    if (state_d == S_ERR && state_q != S_ERR) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule
`default_nettype wire
